// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: strips preamble/SFD from GMII receive bytes and delivers frames with CRC-32, length and PHY-error status.
module gmii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        rgmii_rx_clk,
    input  logic        reset_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [10:0] rx_len,
    output logic [2:0]  err_flags,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_bad
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
    state_t      state, state_nx;
    logic [7:0]  hold;
    logic        hold_vld, first, phy_err;
    logic [10:0] len;
    logic [31:0] crc, crc_rev;
    logic        sfd, data_in, data_end, emit, eof, frame_good, bad_end;
    logic [2:0]  flags;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        return r;
    endfunction
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (gmii_rx_dv) state_nx = gmii_rxd == 8'h55 ? PREAMBLE : gmii_rxd == 8'hD5 ? DATA : DROP;
            PREAMBLE: state_nx = !gmii_rx_dv ? IDLE : gmii_rx_er ? DROP : gmii_rxd == 8'h55 ? PREAMBLE : gmii_rxd == 8'hD5 ? DATA : DROP;
            DATA:     if (!gmii_rx_dv) state_nx = IDLE;
            DROP:     if (!gmii_rx_dv) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // the LSB-first shift register holds the residue bit-reversed
    assign crc_rev    = {<<{crc}};
    assign sfd        = state != DATA && state_nx == DATA;
    assign data_in    = state == DATA && gmii_rx_dv;
    assign data_end   = state == DATA && !gmii_rx_dv;
    assign emit       = state == DATA && hold_vld;
    assign eof        = data_end && hold_vld;
    assign flags      = {phy_err, len < MIN_L || len > MAX_L, crc_rev != CRC_RESIDUE};
    assign frame_good = ~|flags;
    assign bad_end    = (eof && !frame_good) || (data_end && !hold_vld) || (state == DROP && !gmii_rx_dv);
    always_ff @(posedge rgmii_rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_vld  <= 1'b0;
            first     <= 1'b0;
            phy_err   <= 1'b0;
            len       <= '0;
            crc       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_good   <= 1'b0;
            rx_len    <= '0;
            err_flags <= '0;
            cnt_good  <= '0;
            cnt_bad   <= '0;
        end else begin
            state    <= state_nx;
            rx_valid <= emit;
            rx_sof   <= emit && first;
            rx_eof   <= eof;
            rx_good  <= eof && frame_good;
            if (emit)
                rx_data <= hold;
            if (eof) begin
                rx_len    <= len;
                err_flags <= flags;
            end
            if (sfd) begin
                crc      <= '1;
                len      <= '0;
                phy_err  <= 1'b0;
                first    <= 1'b1;
                hold_vld <= 1'b0;
            end else if (data_in) begin
                hold     <= gmii_rxd;
                hold_vld <= 1'b1;
                crc      <= crc_byte(crc, gmii_rxd);
                phy_err  <= phy_err | gmii_rx_er;
                if (len != 11'h7FF)
                    len <= len + 11'd1;
                if (emit)
                    first <= 1'b0;
            end else if (data_end) begin
                hold_vld <= 1'b0;
            end
            if (eof && frame_good && cnt_good != 16'hFFFF)
                cnt_good <= cnt_good + 16'd1;
            if (bad_end && cnt_bad != 16'hFFFF)
                cnt_bad <= cnt_bad + 16'd1;
        end
    end
endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer: directed and randomized frames checked against an FCS-comparison reference model.
module tb_gmii_rx_framer;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    typedef struct packed {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        good;
        logic [10:0] len;
        logic [2:0]  flags;
        logic [31:0] cyc;
    } rec_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_good;
    logic [10:0] rx_len;
    logic [2:0]  err_flags;
    logic [15:0] cnt_good, cnt_bad;
    int          cyc = 0;
    int          total = 0, passed = 0, fails = 0;
    int          exp_good = 0, exp_bad = 0;
    rec_t        got[$];
    rec_t        exp_q[$];
    logic [7:0]  frm[$];
    logic [7:0]  base[$];
    logic [7:0]  none[$];
    int          n, j, b, eofs;
    gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .rgmii_rx_clk(clk),
        .reset_n(reset_n),
        .gmii_rxd(rxd),
        .gmii_rx_dv(dv),
        .gmii_rx_er(er),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_sof(rx_sof),
        .rx_eof(rx_eof),
        .rx_good(rx_good),
        .rx_len(rx_len),
        .err_flags(err_flags),
        .cnt_good(cnt_good),
        .cnt_bad(cnt_bad)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (rx_valid || rx_sof || rx_eof || rx_good)
            got.push_back('{rx_data, rx_sof, rx_eof, rx_good, rx_eof ? rx_len : 11'd0, rx_eof ? err_flags : 3'd0, 32'(cyc)});
    function automatic int sat(input int v);
        return v >= 65535 ? 65535 : v + 1;
    endfunction
    function automatic logic [31:0] crc32(input logic [7:0] f[$], input int cnt);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < cnt; i++)
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ f[i][k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return ~c;
    endfunction
    function automatic void build(input int cnt);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < (cnt >= 4 ? cnt - 4 : cnt); i++)
            frm.push_back(8'($urandom));
        if (cnt >= 4) begin
            c = crc32(frm, cnt - 4);
            for (int i = 0; i < 4; i++)
                frm.push_back(c[8*i +: 8]);
        end
    endfunction
    // expected output: a frame is CRC-good when its trailing four bytes equal the FCS of the rest
    function automatic void model(input logic [7:0] f[$], input int er_at, input int c0);
        int          cnt;
        logic        crc_e, len_e, phy_e;
        logic [10:0] len;
        rec_t        r;
        cnt = f.size();
        if (cnt == 0) begin
            exp_bad = sat(exp_bad);
            return;
        end
        crc_e = 1'b1;
        if (cnt >= 4)
            crc_e = crc32(f, cnt - 4) != {f[cnt-1], f[cnt-2], f[cnt-3], f[cnt-4]};
        len   = cnt > 2047 ? 11'd2047 : 11'(cnt);
        len_e = cnt < MIN_LEN || cnt > MAX_LEN;
        phy_e = er_at >= 0 && er_at < cnt;
        for (int i = 0; i < cnt; i++) begin
            r.data  = f[i];
            r.sof   = i == 0;
            r.eof   = i == cnt - 1;
            r.good  = r.eof && !(crc_e || len_e || phy_e);
            r.len   = r.eof ? len : 11'd0;
            r.flags = r.eof ? {phy_e, len_e, crc_e} : 3'd0;
            r.cyc   = 32'(c0 + 2 + i);
            exp_q.push_back(r);
        end
        if (crc_e || len_e || phy_e)
            exp_bad = sat(exp_bad);
        else
            exp_good = sat(exp_good);
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask
    task automatic drive(input logic v, input logic [7:0] d, input logic e);
        @(negedge clk);
        dv = v;
        rxd = d;
        er = e;
    endtask
    task automatic send(input logic [7:0] f[$], input int npre, input int er_at, input int gap);
        int c0;
        c0 = 0;
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < f.size(); i++) begin
            drive(1'b1, f[i], i == er_at);
            if (i == 0) c0 = cyc;
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
        model(f, er_at, c0);
    endtask
    task automatic drop_burst(input logic [7:0] first_byte, input int cnt);
        drive(1'b1, first_byte, 1'b0);
        for (int i = 1; i < cnt; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        exp_bad = sat(exp_bad);
    endtask
    task automatic drain(input string tag);
        int w;
        w = 0;
        while (got.size() < exp_q.size() && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        chk({tag, " rec count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, " rec"}, 64'(got[i]), 64'(exp_q[i]));
        chk({tag, " cnt_good"}, 64'(cnt_good), 64'(exp_good));
        chk({tag, " cnt_bad"}, 64'(cnt_bad), 64'(exp_bad));
        got.delete();
        exp_q.delete();
    endtask
    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset rx_valid", 64'(rx_valid), 64'd0);
        chk("reset rx_sof", 64'(rx_sof), 64'd0);
        chk("reset rx_eof", 64'(rx_eof), 64'd0);
        chk("reset rx_good", 64'(rx_good), 64'd0);
        chk("reset rx_data", 64'(rx_data), 64'd0);
        chk("reset rx_len", 64'(rx_len), 64'd0);
        chk("reset err_flags", 64'(err_flags), 64'd0);
        chk("reset cnt_good", 64'(cnt_good), 64'd0);
        chk("reset cnt_bad", 64'(cnt_bad), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        build(64);
        base = frm;
        send(base, 7, -1, 1);
        drain("good64");
        frm = base;
        frm[20][3] = ~frm[20][3];
        send(frm, 7, -1, 1);
        drain("crc_flip");
        send(base, 7, 30, 1);
        drain("phy_err");
        build(60);
        send(frm, 7, -1, 1);
        drain("short60");
        build(1);
        send(frm, 7, -1, 1);
        drain("single");
        send(none, 7, -1, 1);
        drain("zero_byte");
        drop_burst(8'h00, 10);
        drain("drop_burst");
        send(base, 7, -1, 1);
        drain("after_drop");
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'hD5, 1'b1);
        drain("pre_abort");
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, base[i], 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        exp_bad = sat(exp_bad);
        drain("pre_er");
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h12, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        exp_bad = sat(exp_bad);
        drain("pre_badbyte");
        for (int k = 0; k < 24; k++) begin
            n = ($urandom_range(0, 8) == 0) ? $urandom_range(1500, 2100) : $urandom_range(1, 110);
            build(n);
            if (n > 4 && $urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, n - 1);
                b = $urandom_range(0, 7);
                frm[j][b] = ~frm[j][b];
            end
            send(frm, $urandom_range(0, 7), ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1, 1);
        end
        drain("random");
        send(base, 7, -1, 1);
        send(base, 0, -1, 1);
        drain("b2b");
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, base[i], 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        dv = 1'b0;
        #1;
        chk("midrst rx_valid", 64'(rx_valid), 64'd0);
        chk("midrst rx_sof", 64'(rx_sof), 64'd0);
        chk("midrst rx_data", 64'(rx_data), 64'd0);
        chk("midrst cnt_good", 64'(cnt_good), 64'd0);
        chk("midrst cnt_bad", 64'(cnt_bad), 64'd0);
        repeat (3) @(negedge clk);
        eofs = 0;
        foreach (got[i]) eofs += int'(got[i].eof);
        chk("midrst no eof", 64'(eofs), 64'd0);
        got.delete();
        exp_q.delete();
        exp_good = 0;
        exp_bad = 0;
        reset_n = 1'b1;
        send(base, 7, -1, 1);
        drain("after_rst");
        @(negedge clk);
        reset_n = 1'b0;
        dv = 1'b1;
        rxd = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        exp_good = 0;
        exp_bad = 1;
        drain("rst_dv_high");
        send(base, 7, -1, 1);
        drain("after_dv_high");
        @(negedge clk);
        force dut.cnt_bad = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_bad;
        exp_bad = 65534;
        drop_burst(8'h00, 2);
        drain("sat1");
        drop_burst(8'h33, 3);
        drain("sat2");
        send(none, 2, -1, 1);
        drain("sat3");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
